// File: rtl/cpu_trace.sv
// Execution trace buffer: captures {PC,A,B,C,D,FLAGS} on SAMPLE into a FWFT FIFO until HALT.
// Optional macro CPU_TRACE_DEDUP_EN suppresses samples identical to the last pushed record.
module cpu_trace #(
    parameter int DEPTH      = 16,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SAMPLE,
    input  logic                       ARM,
    input  logic [15:0]                PC,
    input  logic [7:0]                 A,
    input  logic [7:0]                 B,
    input  logic [7:0]                 C,
    input  logic [7:0]                 D,
    input  logic [7:0]                 FLAGS,
    input  logic                       HALT,
    output logic [55:0]                OUT_DATA,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERFLOW,
    output logic [1:0]                 STATE
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 56;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] CAPTURE = 2'b01;
    localparam logic [1:0] DONE    = 2'b10;

    logic [RW-1:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q;
    logic          valid_q;
    logic [RW-1:0] data_q, data_d;
    logic          overflow_q;

    logic [RW-1:0] record;
    logic          arm_go;
    logic          pop;
    logic          full;
    logic          dup;
    logic          try_push;
    logic          push;
    logic          drop;

`ifdef CPU_TRACE_DEDUP_EN
    logic [RW-1:0] last_q;
    logic          last_valid_q;
`endif

    always_comb begin
        record   = {PC, A, B, C, D, FLAGS};
        arm_go   = ARM && (state_q != CAPTURE);
        pop      = valid_q && OUT_READY;
        full     = (count_q == CW'(DEPTH));
`ifdef CPU_TRACE_DEDUP_EN
        dup      = last_valid_q && (record == last_q);
`else
        dup      = 1'b0;
`endif
        try_push = (state_q == CAPTURE) && SAMPLE && !dup;
        push     = try_push && (!full || pop);
        drop     = try_push && full && !pop;
    end

    always_comb begin
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        // Registered FWFT head: bypass the record being written if it becomes the head.
        if (count_d == '0)
            data_d = '0;
        else if (push && (wptr_q == rptr_d))
            data_d = record;
        else
            data_d = mem[rptr_d];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ARM) state_d = CAPTURE;
            CAPTURE: if (SAMPLE && HALT) state_d = DONE;
            DONE:    if (ARM) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr_q] <= record;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            if (push)
                wptr_q <= wptr_q + AW'(1);
            valid_q <= (count_d != '0);
            data_q  <= data_d;
            if (arm_go)
                overflow_q <= 1'b0;
            else if (drop)
                overflow_q <= 1'b1;
        end
    end

`ifdef CPU_TRACE_DEDUP_EN
    always_ff @(posedge CLK) begin
        if (RST || arm_go) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_q       <= record;
            last_valid_q <= 1'b1;
        end
    end
`endif

    // Output delays only model board timing in simulation; synthesis sees plain wires.
`ifndef SYNTHESIS
    if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_delayed
        assign #(DELAY_RISE, DELAY_FALL) OUT_DATA  = data_q;
        assign #(DELAY_RISE, DELAY_FALL) OUT_VALID = valid_q;
        assign #(DELAY_RISE, DELAY_FALL) COUNT     = count_q;
        assign #(DELAY_RISE, DELAY_FALL) OVERFLOW  = overflow_q;
        assign #(DELAY_RISE, DELAY_FALL) STATE     = state_q;
    end else begin : g_direct
        assign OUT_DATA  = data_q;
        assign OUT_VALID = valid_q;
        assign COUNT     = count_q;
        assign OVERFLOW  = overflow_q;
        assign STATE     = state_q;
    end
`else
    assign OUT_DATA  = data_q;
    assign OUT_VALID = valid_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = overflow_q;
    assign STATE     = state_q;
`endif

endmodule
